// File: rtl/pixel_stream_receiver_if.sv
// pixel_stream_receiver_if
// AXI4-Stream bundle carrying 32-bit RGBX pixels from a source to a sink.
// Signals:
//   tdata  [31:0] pixel {R[31:24], G[23:16], B[15:8], pad[7:0]}
//   tkeep  [3:0]  byte enables, 4'hF for a well-formed beat
//   tlast         end of frame, final pixel only
//   tuser         start of frame, pixel (0,0) only
//   tvalid        source has a beat
//   tready        sink accepts the beat
// Modports: master drives the payload and tvalid, slave drives tready.
interface pixel_stream_receiver_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata, tkeep, tlast, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/pixel_stream_receiver.sv
// pixel_stream_receiver
// AXI4-Stream video sink. Tracks the frame position from tuser/tlast,
// folds every pixel of a frame into an order-sensitive checksum and
// reports framing and keep errors.
// Ports:
//   in_stream_aclk  clock, all logic on its rising edge
//   axi_resetn      asynchronous active-low reset
//   in_stream       pixel stream (slave side)
//   enable          run request, sampled in IDLE and at frame completion
//   clear_err       clears the sticky error flags and drop_count
//   pix_x, pix_y    position of the next expected pixel
//   frame_done      one-cycle pulse per completed frame
//   frame_checksum  checksum of the last completed frame
//   frame_count     completed frames, wraps
//   drop_count      beats discarded while seeking SOF, saturates
//   err_sof         sticky: tuser seen mid-frame
//   err_eof         sticky: tlast early or missing
//   err_keep        sticky: tkeep != 4'hF on an accepted beat
//
// state       | meaning
// ------------+----------------------------------------------------
// ST_IDLE     | stopped, tready low, waiting for enable
// ST_SEEK_SOF | discarding beats until one carries tuser
// ST_IN_FRAME | receiving pixels of a frame
module pixel_stream_receiver #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic                          in_stream_aclk,
  input  logic                          axi_resetn,
  pixel_stream_receiver_if.slave        in_stream,
  input  logic                          enable,
  input  logic                          clear_err,
  output logic [9:0]                    pix_x,
  output logic [8:0]                    pix_y,
  output logic                          frame_done,
  output logic [31:0]                   frame_checksum,
  output logic [15:0]                   frame_count,
  output logic [15:0]                   drop_count,
  output logic                          err_sof,
  output logic                          err_eof,
  output logic                          err_keep
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEEK_SOF = 2'd1,
    ST_IN_FRAME = 2'd2
  } state_t;

  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  state_t      state, state_nxt;
  logic [31:0] acc, acc_nxt;
  logic [9:0]  pix_x_nxt;
  logic [8:0]  pix_y_nxt;
  logic        frame_done_nxt;
  logic [31:0] frame_checksum_nxt;
  logic [15:0] frame_count_nxt;
  logic [15:0] drop_count_nxt;
  logic        err_sof_nxt, err_eof_nxt, err_keep_nxt;

  logic        beat;
  logic        sof_pixel;
  logic        framed;
  logic        drop_evt;
  logic        set_sof, set_eof, set_keep;
  logic [9:0]  cur_x;
  logic [8:0]  cur_y;
  logic [31:0] acc_beat;
  logic        is_final;
  logic [15:0] drop_base;

  assign in_stream.tready = (state != ST_IDLE);
  assign beat             = in_stream.tvalid & in_stream.tready;

  // A tuser beat is pixel (0,0) whether it opens a frame or resyncs one,
  // so the position and accumulator restart from the beat itself.
  assign sof_pixel = beat & in_stream.tuser;
  assign cur_x     = sof_pixel ? 10'd0 : pix_x;
  assign cur_y     = sof_pixel ? 9'd0  : pix_y;
  assign acc_beat  = sof_pixel ? in_stream.tdata
                               : ({acc[30:0], acc[31]} ^ in_stream.tdata);
  assign is_final  = (cur_x == X_LAST) && (cur_y == Y_LAST);
  assign set_keep  = beat & (in_stream.tkeep != 4'hF);

  always_comb begin
    state_nxt          = state;
    acc_nxt            = acc;
    pix_x_nxt          = pix_x;
    pix_y_nxt          = pix_y;
    frame_done_nxt     = 1'b0;
    frame_checksum_nxt = frame_checksum;
    frame_count_nxt    = frame_count;
    framed             = 1'b0;
    drop_evt           = 1'b0;
    set_sof            = 1'b0;
    set_eof            = 1'b0;

    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_SEEK_SOF;
      end
      ST_SEEK_SOF: begin
        if (beat) begin
          if (in_stream.tuser) framed   = 1'b1;
          else                 drop_evt = 1'b1;
        end
      end
      ST_IN_FRAME: begin
        if (beat) begin
          framed  = 1'b1;
          set_sof = in_stream.tuser;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (framed) begin
      if (is_final) begin
        // Completion wins over tlast checking: a missing tlast is only flagged.
        set_eof            = ~in_stream.tlast;
        frame_checksum_nxt = acc_beat;
        frame_done_nxt     = 1'b1;
        frame_count_nxt    = frame_count + 16'd1;
        acc_nxt            = 32'd0;
        pix_x_nxt          = 10'd0;
        pix_y_nxt          = 9'd0;
        state_nxt          = enable ? ST_SEEK_SOF : ST_IDLE;
      end else if (in_stream.tlast) begin
        set_eof   = 1'b1;
        acc_nxt   = 32'd0;
        pix_x_nxt = 10'd0;
        pix_y_nxt = 9'd0;
        state_nxt = ST_SEEK_SOF;
      end else begin
        acc_nxt   = acc_beat;
        state_nxt = ST_IN_FRAME;
        if (cur_x == X_LAST) begin
          pix_x_nxt = 10'd0;
          pix_y_nxt = cur_y + 9'd1;
        end else begin
          pix_x_nxt = cur_x + 10'd1;
          pix_y_nxt = cur_y;
        end
      end
    end

    // Set beats clear in the same cycle: the clear applies first.
    drop_base      = clear_err ? 16'd0 : drop_count;
    drop_count_nxt = (drop_evt && drop_base != 16'hFFFF) ? drop_base + 16'd1
                                                         : drop_base;
    err_sof_nxt    = (err_sof  & ~clear_err) | set_sof;
    err_eof_nxt    = (err_eof  & ~clear_err) | set_eof;
    err_keep_nxt   = (err_keep & ~clear_err) | set_keep;
  end

  always_ff @(posedge in_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state          <= ST_IDLE;
      acc            <= 32'd0;
      pix_x          <= 10'd0;
      pix_y          <= 9'd0;
      frame_done     <= 1'b0;
      frame_checksum <= 32'd0;
      frame_count    <= 16'd0;
      drop_count     <= 16'd0;
      err_sof        <= 1'b0;
      err_eof        <= 1'b0;
      err_keep       <= 1'b0;
    end else begin
      state          <= state_nxt;
      acc            <= acc_nxt;
      pix_x          <= pix_x_nxt;
      pix_y          <= pix_y_nxt;
      frame_done     <= frame_done_nxt;
      frame_checksum <= frame_checksum_nxt;
      frame_count    <= frame_count_nxt;
      drop_count     <= drop_count_nxt;
      err_sof        <= err_sof_nxt;
      err_eof        <= err_eof_nxt;
      err_keep       <= err_keep_nxt;
    end
  end

endmodule

// File: doc/pixel_stream_receiver.md
Name: pixel_stream_receiver

Overview:
- AXI4-Stream video sink: the receiving end of the 32-bit RGBX pixel stream produced by the pixel generator.
- Accepts beats, tracks the frame position (x, y) using tuser (start of frame) and tlast (end of frame, asserted only on the final pixel), and computes an order-sensitive per-frame checksum.
- Reports framing and keep errors.
- Used as a loopback/verification sink in simulation and as an on-chip stream monitor.

Parameters:
X_SIZE, 640, pixels per line
Y_SIZE, 480, lines per frame

Ports:
in_stream_aclk  in  1  clock; all logic on its rising edge
axi_resetn  in  1  asynchronous active-low reset
in_stream_tdata  in  32  pixel {R[31:24],G[23:16],B[15:8],pad[7:0]}
in_stream_tkeep  in  4  byte enables; 4'hF expected
in_stream_tlast  in  1  end of frame, final pixel only
in_stream_tuser  in  1  start of frame, pixel (0,0) only
in_stream_tvalid  in  1  beat valid
in_stream_tready  out  1  sink ready
enable  in  1  run request
clear_err  in  1  clears sticky errors and drop_count
pix_x  out  10  x of the next expected pixel
pix_y  out  9  y of the next expected pixel
frame_done  out  1  one-cycle pulse per completed frame
frame_checksum  out  32  checksum of the last completed frame
frame_count  out  16  completed frames, wraps at 2^16
drop_count  out  16  beats discarded while seeking SOF, saturates at 16'hFFFF
err_sof  out  1  sticky: tuser seen mid-frame
err_eof  out  1  sticky: tlast early or missing
err_keep  out  1  sticky: tkeep != 4'hF on an accepted beat

Behaviour:
- Reset (async assert, sync release): state IDLE; every output, pix_x/pix_y and the accumulator are 0.
- beat = tvalid & tready. tready = (state != IDLE), registered-free combinational decode of state. No other stall source.
- States:
  - IDLE: if enable=1, go to SEEK_SOF next cycle.
  - SEEK_SOF: a beat with tuser=0 is discarded and increments drop_count (saturating). A beat with tuser=1 is pixel (0,0): acc <= tdata, pix_x <= 1, go to IN_FRAME.
  - IN_FRAME, beat with tuser=1 (resync): set err_sof; treat the beat as a new pixel (0,0) (acc <= tdata, pix_x=1, pix_y=0); stay IN_FRAME.
  - IN_FRAME, normal beat: acc <= {acc[30:0],acc[31]} ^ tdata. pix_x increments, wrapping to 0 at X_SIZE-1 with pix_y +1.
  - IN_FRAME, tlast=1 on a non-final pixel: set err_eof, abort the frame (no frame_done, count unchanged), go to SEEK_SOF, clear pix_x/pix_y.
  - IN_FRAME, final pixel (X_SIZE-1, Y_SIZE-1): if tlast=0, set err_eof; the frame completes either way.
- Frame completion (at the edge that accepts the final beat):
  - frame_checksum <= final acc value; frame_done=1 for exactly that next cycle; frame_count +1; pix_x/pix_y return to 0.
  - Next state: SEEK_SOF if enable=1, otherwise IDLE.
- enable=0 mid-frame does not stop reception. It is sampled only in IDLE and at frame completion.
- Single-pixel frame (X_SIZE=Y_SIZE=1): the SOF beat is also the final beat. Completion and the SOF rules apply in the same cycle.
- err_keep: set on any accepted beat with tkeep != 4'hF, including discarded beats. The beat is still processed normally.
- clear_err clears err_* and drop_count. If a set condition occurs in the same cycle, set wins.
- Reset mid-frame: immediate return to reset values. The partial frame is lost.
- Latency: frame_done and frame_checksum are valid 1 cycle after the final beat handshake.

Test Plan:
All scenarios use X_SIZE=4, Y_SIZE=2, with enable=1 after reset.
1. Clean frame, tdata = pixel index 0..7, tuser on beat 0, tlast on beat 7, tvalid constant -> frame_done pulse 1 cycle after beat 7, frame_checksum=32'h0000000F, frame_count=1, no errors.
2. Same frame with random tvalid gaps, then a second identical frame -> checksum 32'h0F both times, frame_count=2, pix_x/pix_y correct at every gap.
3. 3 beats with tuser=0, then a clean frame -> drop_count=3, frame_checksum=32'h0F, no err flags.
4. tlast on beat 5 -> err_eof=1, no frame_done, frame_count unchanged; next clean frame gives checksum 32'h0F. Then pulse clear_err -> err_eof=0, drop_count=0.
5. tuser re-asserted on beat 3, followed by 8 beats of pixel index 0..7 -> err_sof=1, frame_done once, checksum 32'h0F; tkeep=4'h7 on one beat -> err_keep=1.
6. axi_resetn pulsed low asynchronously mid-frame (between clock edges) -> all outputs 0 immediately; after release a clean frame gives checksum 32'h0F. enable=0 at completion -> tready=0 afterwards.
